// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory responder: one outstanding burst per direction, FIXED/INCR/WRAP, byte strobes.
// Write path AW -> W beats -> B; read path AR -> R beats; both share one word array.
module axi4_slave_mem #(
  parameter  int ID_WIDTH   = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int LEN_WIDTH  = 8,
  parameter  int DATA_WIDTH = 256,
  parameter  int MEM_WORDS  = 1024,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESETn,
  input  logic [ID_WIDTH-1:0]   AXI_AWID,
  input  logic [ADDR_WIDTH-1:0] AXI_AWADDR,
  input  logic [LEN_WIDTH-1:0]  AXI_AWLEN,
  input  logic [2:0]            AXI_AWSIZE,
  input  logic [1:0]            AXI_AWBURST,
  input  logic                  AXI_AWVALID,
  output logic                  AXI_AWREADY,
  input  logic [ID_WIDTH-1:0]   AXI_WID,
  input  logic [DATA_WIDTH-1:0] AXI_WDATA,
  input  logic [STRB_WIDTH-1:0] AXI_WSTRB,
  input  logic                  AXI_WLAST,
  input  logic                  AXI_WVALID,
  output logic                  AXI_WREADY,
  output logic [ID_WIDTH-1:0]   AXI_BID,
  output logic [1:0]            AXI_BRESP,
  output logic                  AXI_BVALID,
  input  logic                  AXI_BREADY,
  input  logic [ID_WIDTH-1:0]   AXI_ARID,
  input  logic [ADDR_WIDTH-1:0] AXI_ARADDR,
  input  logic [LEN_WIDTH-1:0]  AXI_ARLEN,
  input  logic [2:0]            AXI_ARSIZE,
  input  logic [1:0]            AXI_ARBURST,
  input  logic                  AXI_ARVALID,
  output logic                  AXI_ARREADY,
  output logic [ID_WIDTH-1:0]   AXI_RID,
  output logic [DATA_WIDTH-1:0] AXI_RDATA,
  output logic [1:0]            AXI_RRESP,
  output logic                  AXI_RLAST,
  output logic                  AXI_RVALID,
  input  logic                  AXI_RREADY
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS) << ADDR_LSB;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [LEN_WIDTH-1:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] bytes, bound, base;
    bytes = ADDR_WIDTH'(1) << size;
    bound = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    base  = addr & ~(bound - ADDR_WIDTH'(1));
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = base | ((addr + bytes) & (bound - ADDR_WIDTH'(1)));
      default: next_addr = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    endcase
  endfunction

  function automatic logic wrap_len_ok(input logic [LEN_WIDTH-1:0] len);
    return len == LEN_WIDTH'(1) || len == LEN_WIDTH'(3) ||
           len == LEN_WIDTH'(7) || len == LEN_WIDTH'(15);
  endfunction

  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [LEN_WIDTH-1:0] len);
    return (size > 3'(ADDR_LSB)) || (burst == 2'b11) || (burst == 2'b10 && !wrap_len_ok(len));
  endfunction

  // Reserved burst type and illegal wrap lengths degrade to INCR.
  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [LEN_WIDTH-1:0] len);
    return (burst == 2'b11 || (burst == 2'b10 && !wrap_len_ok(len))) ? 2'b01 : burst;
  endfunction

  function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} >= MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_LSB +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic                  rdy_en_q;

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [LEN_WIDTH-1:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;
  logic                  awready, wready, bvalid, mem_we;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next_addr, r_fetch_addr;
  logic [LEN_WIDTH-1:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic                  r_cfg_err_q, r_cfg_err_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d, r_fetch_word;
  logic                  r_last_q, r_last_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  arready, rvalid;

  logic unused_wid;
  assign unused_wid = ^AXI_WID;

  // Ready outputs stay low until the first clock after reset release.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETn) begin
    if (!AXI_ARESETn) rdy_en_q <= 1'b0;
    else              rdy_en_q <= 1'b1;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (AXI_WSTRB[i]) mem_q[word_idx(w_addr_q)][i*8 +: 8] <= AXI_WDATA[i*8 +: 8];
      end
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETn) begin
    if (!AXI_ARESETn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: if (AXI_AWVALID && awready) begin
        w_id_d    = AXI_AWID;
        w_addr_d  = AXI_AWADDR;
        w_len_d   = AXI_AWLEN;
        w_size_d  = AXI_AWSIZE;
        w_burst_d = eff_burst(AXI_AWBURST, AXI_AWLEN);
        w_err_d   = cfg_err(AXI_AWSIZE, AXI_AWBURST, AXI_AWLEN);
        w_cnt_d   = '0;
        w_state_d = W_DATA;
      end
      W_DATA: if (AXI_WVALID) begin
        w_err_d  = w_err_q | addr_oob(w_addr_q) | (AXI_WLAST != (w_cnt_q == w_len_q));
        w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
        w_cnt_d  = w_cnt_q + LEN_WIDTH'(1);
        if (w_cnt_q == w_len_q) w_state_d = W_RESP;
      end
      W_RESP: if (AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE:  awready = rdy_en_q;
      W_DATA:  wready  = 1'b1;
      W_RESP:  bvalid  = 1'b1;
      default: ;
    endcase
  end

  assign mem_we      = wready && AXI_WVALID && !addr_oob(w_addr_q);
  assign AXI_AWREADY = awready;
  assign AXI_WREADY  = wready;
  assign AXI_BVALID  = bvalid;
  assign AXI_BID     = w_id_q;
  assign AXI_BRESP   = {w_err_q, 1'b0};

  // ---------------- read FSM ----------------
  // Each beat's data is captured when it is launched, so a same-cycle write is not visible.
  assign r_next_addr  = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
  assign r_fetch_addr = (r_state_q == R_IDLE) ? AXI_ARADDR : r_next_addr;
  assign r_fetch_word = addr_oob(r_fetch_addr) ? '0 : mem_q[word_idx(r_fetch_addr)];

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETn) begin
    if (!AXI_ARESETn) begin
      r_state_q   <= R_IDLE;
      r_id_q      <= '0;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      r_size_q    <= '0;
      r_burst_q   <= '0;
      r_cfg_err_q <= 1'b0;
      r_data_q    <= '0;
      r_last_q    <= 1'b0;
      r_resp_q    <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_id_q      <= r_id_d;
      r_addr_q    <= r_addr_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      r_size_q    <= r_size_d;
      r_burst_q   <= r_burst_d;
      r_cfg_err_q <= r_cfg_err_d;
      r_data_q    <= r_data_d;
      r_last_q    <= r_last_d;
      r_resp_q    <= r_resp_d;
    end
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_id_d      = r_id_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_size_d    = r_size_q;
    r_burst_d   = r_burst_q;
    r_cfg_err_d = r_cfg_err_q;
    r_data_d    = r_data_q;
    r_last_d    = r_last_q;
    r_resp_d    = r_resp_q;
    case (r_state_q)
      R_IDLE: if (AXI_ARVALID && arready) begin
        r_id_d      = AXI_ARID;
        r_addr_d    = AXI_ARADDR;
        r_len_d     = AXI_ARLEN;
        r_size_d    = AXI_ARSIZE;
        r_burst_d   = eff_burst(AXI_ARBURST, AXI_ARLEN);
        r_cfg_err_d = cfg_err(AXI_ARSIZE, AXI_ARBURST, AXI_ARLEN);
        r_cnt_d     = '0;
        r_data_d    = r_fetch_word;
        r_last_d    = (AXI_ARLEN == '0);
        r_resp_d    = {r_cfg_err_d | addr_oob(AXI_ARADDR), 1'b0};
        r_state_d   = R_DATA;
      end
      R_DATA: if (AXI_RREADY) begin
        if (r_last_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_addr_d = r_next_addr;
          r_cnt_d  = r_cnt_q + LEN_WIDTH'(1);
          r_data_d = r_fetch_word;
          r_last_d = (r_cnt_d == r_len_q);
          r_resp_d = {r_cfg_err_q | addr_oob(r_next_addr), 1'b0};
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE:  arready = rdy_en_q;
      R_DATA:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign AXI_ARREADY = arready;
  assign AXI_RVALID  = rvalid;
  assign AXI_RID     = r_id_q;
  assign AXI_RDATA   = r_data_q;
  assign AXI_RRESP   = r_resp_q;
  assign AXI_RLAST   = r_last_q;

endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
AXI4 slave memory responder that consumes the AXI4 bus driven by the master VIP (connected through the AXI interface bundle). It is the terminating stage for master-VIP bring-up and scoreboarding. It has independent write and read state machines, one outstanding transaction per direction, and supports FIXED, INCR and WRAP bursts with byte strobes. It is a synthesizable-style behavioural model with a DATA_WIDTH-wide word array.

Parameters:
ID_WIDTH, 4, width of AWID/BID/ARID/RID
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 8, AWLEN/ARLEN width
DATA_WIDTH, 256, data bus width; STRB_WIDTH = DATA_WIDTH/8
MEM_WORDS, 1024, array depth in DATA_WIDTH words (power of two)

Ports:
AXI_ACLK  in  1  clock
AXI_ARESETn  in  1  asynchronous active-low reset
AXI_AWID, AXI_AWADDR, AXI_AWLEN  in  ID/ADDR/LEN_WIDTH  write address channel
AXI_AWSIZE, AXI_AWBURST  in  3/2  write beat size and burst type
AXI_AWVALID  in  1; AXI_AWREADY  out  1  AW handshake
AXI_WID  in  ID_WIDTH  ignored (AXI3 legacy)
AXI_WDATA  in  DATA_WIDTH; AXI_WSTRB  in  STRB_WIDTH; AXI_WLAST  in  1  write data
AXI_WVALID  in  1; AXI_WREADY  out  1  W handshake
AXI_BID  out  ID_WIDTH; AXI_BRESP  out  2  write response
AXI_BVALID  out  1; AXI_BREADY  in  1  B handshake
AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST  in  as AW  read address channel
AXI_ARVALID  in  1; AXI_ARREADY  out  1  AR handshake
AXI_RID  out  ID_WIDTH; AXI_RDATA  out  DATA_WIDTH; AXI_RRESP  out  2; AXI_RLAST  out  1  read data
AXI_RVALID  out  1; AXI_RREADY  in  1  R handshake
(AWLOCK/AWCACHE/AWPROT/AWQOS and AR equivalents are not connected; ignored.)

Behaviour:
- Interface decided: single clock AXI_ACLK; reset AXI_ARESETn is asynchronous, active-low.
- Reset: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, ARREADY=0, RVALID=0, RLAST=0, RID=0, RRESP=0, RDATA=0. Both FSMs go to idle. Memory contents are retained, not cleared. Reset mid-burst abandons the burst with no response.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, capture id/addr/len/size/burst, clear the error flag and beat counter, then go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&&WREADY beat writes the bytes where WSTRB[i]=1 into word addr[ADDR_LSB +: log2(MEM_WORDS)], with ADDR_LSB=log2(STRB_WIDTH). The address then advances and the counter increments. On the beat where count==len, go to W_RESP.
  - W_RESP: BVALID=1 in the cycle after the last W handshake; BID = captured id. Hold BVALID and BID stable until BREADY, then go to W_IDLE. AWREADY stays 0 until back in W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On handshake, capture id/addr/len/size/burst.
  - R_DATA: RVALID asserts the cycle after the AR handshake, with RDATA = full word at the current address, RID = captured id, and RLAST=1 on beat len.
  - R outputs hold stable while RVALID&&!RREADY. After each accepted beat the next beat is presented the next cycle (full throughput). After the RLAST beat is accepted, go to R_IDLE.
- Address advance (bytes = 1<<size):
  - FIXED (00): unchanged.
  - INCR (01): addr = (addr & ~(bytes-1)) + bytes, with ADDR_WIDTH wrap-around.
  - WRAP (10): boundary = bytes*(len+1); addr = base | ((addr+bytes) & (boundary-1)), where base = addr & ~(boundary-1).
- Errors give SLVERR (2'b10), otherwise OKAY (00). Write BRESP is the OR of errors over the whole burst. RRESP is per beat.
  - size > log2(STRB_WIDTH): SLVERR.
  - burst==11: SLVERR, treated as INCR.
  - WRAP with len not in {1,3,7,15}: SLVERR, treated as INCR.
  - Address >= MEM_WORDS*STRB_WIDTH: SLVERR; the write is dropped and the read returns 0.
  - WLAST mismatch (asserted before beat len, or deasserted on beat len): SLVERR; the burst still ends on beat len.
- Narrow writes use WSTRB as supplied. Narrow reads return the full word.
- Read and write run concurrently. If a read beat and a write beat hit the same word in the same cycle, the read returns pre-write data.

Test Plan:
- INCR write AWADDR=0x100, AWLEN=3, AWSIZE=5, WSTRB=all-ones, data 0xA0..0xA3 -> BRESP=00 one cycle after the 4th beat, BID=AWID. INCR read of the same burst -> RDATA 0xA0..0xA3, RLAST only on beat 3, RRESP=00.
- WRAP read ARADDR=0x160, ARLEN=3, ARSIZE=5 -> beat addresses 0x160, 0x100, 0x120, 0x140. ARLEN=2 with WRAP -> RRESP=10 on every beat.
- Partial strobe: write 0xFF.. to 0x0, then write WSTRB=0x0000_0001 with data 0x11 -> read 0x0 returns byte0=0x11, other bytes 0xFF.
- Backpressure: BREADY held low 5 cycles -> BVALID/BID/BRESP stable and AWREADY=0 throughout. RREADY toggling -> no beat lost or duplicated.
- Error: write to 0x8000 (MEM_WORDS=1024) -> BRESP=10 and memory unchanged. AWLEN=3 with WLAST on beat 1 -> BRESP=10, 4 beats consumed.
- Reset asserted mid read burst (beat 2 of 8) -> RVALID=0 asynchronously. After release ARREADY=1 and a new burst completes normally; previously written data is still intact.
